// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache sitting between the fetch PC and
// a slow backing instruction memory. Hits return data in the same cycle.
// A miss stalls fetch and refills the whole line, one beat per memReady
// cycle. Hit and miss counters are kept for performance measurement.
module instr_cache #(
    parameter int          LINES = 16,
    parameter int          WORDS = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        missStall,
    output logic        memReq,
    output logic [31:0] memAdr,
    input  logic [31:0] memData,
    input  logic        memReady,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
);

    localparam int OFF_W    = $clog2(WORDS);
    localparam int IDX_W    = $clog2(LINES);
    localparam int LINE_LSB = 2 + OFF_W;
    localparam int TAG_LSB  = LINE_LSB + IDX_W;
    localparam int TAG_W    = 32 - TAG_LSB;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]       state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS];
    logic [OFF_W-1:0] beat;
    logic [31:0]      refill_base;

    // Fields of the current fetch address.
    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    assign pc_off = pc[LINE_LSB-1:2];
    assign pc_idx = pc[TAG_LSB-1:LINE_LSB];
    assign pc_tag = pc[31:TAG_LSB];

    // The refilling line's index and tag come straight from the latched base,
    // so a branch redirect during refill cannot corrupt the fill.
    logic [IDX_W-1:0] refill_idx;
    logic [TAG_W-1:0] refill_tag;
    assign refill_idx = refill_base[TAG_LSB-1:LINE_LSB];
    assign refill_tag = refill_base[31:TAG_LSB];

    logic hit;
    logic idle;
    logic beat_fire;
    logic last_beat;

    assign hit       = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign idle      = (state == IDLE);
    assign beat_fire = (state == REFILL) && memReady;
    assign last_beat = (beat == OFF_W'(WORDS - 1));

    // Fetch-side outputs: same-cycle data on an idle hit, NOP otherwise.
    always_comb begin
        instruction = NOP;
        if (hit && idle)
            instruction = data_mem[{pc_idx, pc_off}];
    end

    assign missStall = !hit || !idle;

    // Refill bus: the base is line aligned, so the beat just fills the offset.
    always_comb begin
        memReq = 1'b0;
        memAdr = 32'h0;
        if (state == REFILL) begin
            memReq = 1'b1;
            memAdr = {refill_base[31:LINE_LSB], beat, 2'b00};
        end
    end

    // Control state, valid bits and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            beat        <= '0;
            refill_base <= 32'h0;
            hitCount    <= 32'h0;
            missCount   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        hitCount <= hitCount + 32'd1;
                    end else begin
                        // Invalidate now so the evicted line never hits mid-fill.
                        refill_base   <= {pc[31:LINE_LSB], {LINE_LSB{1'b0}}};
                        beat          <= '0;
                        valid[pc_idx] <= 1'b0;
                        missCount     <= missCount + 32'd1;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (memReady) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[refill_idx] <= 1'b1;
                            state             <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage; written only by refill beats, never reset.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            data_mem[{refill_idx, beat}] <= memData;
            if (last_beat)
                tag_mem[refill_idx] <= refill_tag;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache (LINES=16, WORDS=4). The backing memory
// returns 0xA0 + (address/4) for every word address.
module tb_instr_cache;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        missStall;
    logic        memReq;
    logic [31:0] memAdr;
    logic [31:0] memData;
    logic        memReady;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    int tests = 0;
    int fails = 0;
    int cyc;
    int n_adr;
    logic [31:0] adr_log [16];

    logic        bp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] bp_adr [7] = '{32'h20, 32'h24, 32'h24, 32'h24, 32'h28, 32'h2C, 32'h2C};

    always #5 clk = ~clk;

    assign memData = 32'hA0 + {2'b00, memAdr[31:2]};

    instr_cache #(.LINES(16), .WORDS(4), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
        .missStall(missStall), .memReq(memReq), .memAdr(memAdr),
        .memData(memData), .memReady(memReady),
        .hitCount(hitCount), .missCount(missCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answers every beat immediately and logs beat addresses until the stall
    // clears; the cycle count is bounded so a stuck DUT cannot hang the run.
    task automatic run_miss(output int cycles);
        n_adr = 0;
        cycles = 0;
        memReady = 1'b1;
        while (missStall && cycles < 40) begin
            if (memReq && memReady && n_adr < 16) begin
                adr_log[n_adr] = memAdr;
                n_adr++;
            end
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'h0; memReady = 1'b0;
        tick(); tick();
        tests++; if (memReq !== 1'b0) begin fails++; $display("FAIL rst_memReq: got %b expected 0", memReq); end
        tests++; if (memAdr !== 32'h0) begin fails++; $display("FAIL rst_memAdr: got %h expected 0", memAdr); end
        tests++; if (instruction !== NOP) begin fails++; $display("FAIL rst_instr: got %h expected %h", instruction, NOP); end
        tests++; if (missStall !== 1'b1) begin fails++; $display("FAIL rst_stall: got %b expected 1", missStall); end
        tests++; if (hitCount !== 32'h0) begin fails++; $display("FAIL rst_hits: got %0d expected 0", hitCount); end
        tests++; if (missCount !== 32'h0) begin fails++; $display("FAIL rst_misses: got %0d expected 0", missCount); end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        pc = 32'h0;
        run_miss(cyc);
        tests++; if (cyc != 5) begin fails++; $display("FAIL cold_stall_cycles: got %0d expected 5", cyc); end
        tests++; if (n_adr != 4) begin fails++; $display("FAIL cold_beats: got %0d expected 4", n_adr); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (adr_log[i] !== 32'(4 * i)) begin fails++; $display("FAIL cold_adr%0d: got %h expected %h", i, adr_log[i], 32'(4 * i)); end
        end
        tests++; if (instruction !== 32'hA0) begin fails++; $display("FAIL cold_instr: got %h expected a0", instruction); end
        tests++; if (missCount !== 32'd1) begin fails++; $display("FAIL cold_misses: got %0d expected 1", missCount); end
    endtask

    task automatic test_hits();
        for (int i = 1; i < 4; i++) begin
            pc = 32'(4 * i);
            #1;
            tests++; if (instruction !== 32'(32'hA0 + i)) begin fails++; $display("FAIL hit_instr%0d: got %h expected %h", i, instruction, 32'(32'hA0 + i)); end
            tests++; if (missStall !== 1'b0) begin fails++; $display("FAIL hit_stall%0d: got %b expected 0", i, missStall); end
            tick();
            tests++; if (hitCount !== 32'(i)) begin fails++; $display("FAIL hit_count%0d: got %0d expected %0d", i, hitCount, i); end
        end
    endtask

    task automatic test_backpressure();
        pc = 32'h20; memReady = 1'b1;
        #1;
        tests++; if (missStall !== 1'b1 || memReq !== 1'b0) begin fails++; $display("FAIL bp_miss_cycle: got stall=%b req=%b expected 1 0", missStall, memReq); end
        tick();
        for (int i = 0; i < 7; i++) begin
            memReady = bp_rdy[i];
            #1;
            tests++; if (memReq !== 1'b1 || memAdr !== bp_adr[i] || missStall !== 1'b1) begin
                fails++; $display("FAIL bp_cycle%0d: got req=%b adr=%h stall=%b expected 1 %h 1", i, memReq, memAdr, missStall, bp_adr[i]);
            end
            tick();
        end
        memReady = 1'b0;
        tests++; if (missStall !== 1'b0 || instruction !== 32'hA8) begin fails++; $display("FAIL bp_done: got stall=%b instr=%h expected 0 a8", missStall, instruction); end
        tests++; if (missCount !== 32'd2) begin fails++; $display("FAIL bp_misses: got %0d expected 2", missCount); end
        for (int i = 1; i < 4; i++) begin
            pc = 32'(32'h20 + 4 * i);
            #1;
            tests++; if (instruction !== 32'(32'hA8 + i)) begin fails++; $display("FAIL bp_word%0d: got %h expected %h", i, instruction, 32'(32'hA8 + i)); end
        end
    endtask

    task automatic test_eviction();
        pc = 32'h100;
        #1;
        tests++; if (missStall !== 1'b1) begin fails++; $display("FAIL evict_new_miss: got %b expected 1", missStall); end
        run_miss(cyc);
        tests++; if (cyc != 5 || adr_log[0] !== 32'h100) begin fails++; $display("FAIL evict_refill: got cycles=%0d adr0=%h expected 5 100", cyc, adr_log[0]); end
        tests++; if (instruction !== 32'hE0) begin fails++; $display("FAIL evict_instr: got %h expected e0", instruction); end
        tests++; if (missCount !== 32'd3) begin fails++; $display("FAIL evict_misses: got %0d expected 3", missCount); end
        pc = 32'h0;
        #1;
        tests++; if (missStall !== 1'b1) begin fails++; $display("FAIL evict_old_miss: got %b expected 1", missStall); end
        run_miss(cyc);
        tests++; if (instruction !== 32'hA0) begin fails++; $display("FAIL evict_refetch: got %h expected a0", instruction); end
        tests++; if (missCount !== 32'd4) begin fails++; $display("FAIL evict_misses2: got %0d expected 4", missCount); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp [6] = '{32'h48, 32'h4C, 32'h80, 32'h84, 32'h88, 32'h8C};
        pc = 32'h40; memReady = 1'b1;
        tick(); tick(); tick();
        pc = 32'h80;
        run_miss(cyc);
        tests++; if (cyc != 7 || n_adr != 6) begin fails++; $display("FAIL redir_len: got cycles=%0d beats=%0d expected 7 6", cyc, n_adr); end
        for (int i = 0; i < 6; i++) begin
            tests++; if (adr_log[i] !== exp[i]) begin fails++; $display("FAIL redir_adr%0d: got %h expected %h", i, adr_log[i], exp[i]); end
        end
        tests++; if (instruction !== 32'hC0) begin fails++; $display("FAIL redir_instr: got %h expected c0", instruction); end
        tests++; if (missCount !== 32'd6) begin fails++; $display("FAIL redir_misses: got %0d expected 6", missCount); end
        pc = 32'h40;
        #1;
        tests++; if (missStall !== 1'b0 || instruction !== 32'hB0) begin fails++; $display("FAIL redir_old_hit: got stall=%b instr=%h expected 0 b0", missStall, instruction); end
        pc = 32'h4C;
        #1;
        tests++; if (instruction !== 32'hB3) begin fails++; $display("FAIL redir_old_w3: got %h expected b3", instruction); end
    endtask

    task automatic test_reset_mid_refill();
        pc = 32'hC0; memReady = 1'b1;
        tick(); tick(); tick(); tick();
        tests++; if (memReq !== 1'b1 || memAdr !== 32'hCC) begin fails++; $display("FAIL mid_pre: got req=%b adr=%h expected 1 cc", memReq, memAdr); end
        rst = 1'b1;
        #1;
        tests++; if (memReq !== 1'b0 || memAdr !== 32'h0) begin fails++; $display("FAIL mid_req: got req=%b adr=%h expected 0 0", memReq, memAdr); end
        tests++; if (hitCount !== 32'h0 || missCount !== 32'h0) begin fails++; $display("FAIL mid_counts: got %0d %0d expected 0 0", hitCount, missCount); end
        tests++; if (missStall !== 1'b1 || instruction !== NOP) begin fails++; $display("FAIL mid_out: got stall=%b instr=%h expected 1 %h", missStall, instruction, NOP); end
        tick();
        rst = 1'b0;
        run_miss(cyc);
        tests++; if (cyc != 5 || n_adr != 4) begin fails++; $display("FAIL mid_refill_len: got cycles=%0d beats=%0d expected 5 4", cyc, n_adr); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (adr_log[i] !== 32'(32'hC0 + 4 * i)) begin fails++; $display("FAIL mid_adr%0d: got %h expected %h", i, adr_log[i], 32'(32'hC0 + 4 * i)); end
        end
        tests++; if (instruction !== 32'hD0 || missCount !== 32'd1) begin fails++; $display("FAIL mid_result: got instr=%h misses=%0d expected d0 1", instruction, missCount); end
        tick();
        tests++; if (hitCount !== 32'd1) begin fails++; $display("FAIL mid_hits: got %0d expected 1", hitCount); end
        pc = 32'h40;
        #1;
        tests++; if (missStall !== 1'b1) begin fails++; $display("FAIL mid_invalidated: got %b expected 1", missStall); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_backpressure();
        test_eviction();
        test_redirect();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC register and a slow backing instruction memory.
- On a hit it returns the instruction in the same cycle, acting as a drop-in instruction-memory replacement.
- On a miss it raises missStall, which is ORed into stallF/stallD by the hazard logic. It then runs a multi-beat line refill over a ready-handshake bus.
- Keeps 32-bit hit and miss counters for performance measurement.

Parameters:
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.
- NOP, 32'h00000013, instruction driven while a miss is outstanding.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc  input  32  fetch address (PCF); bits [1:0] are ignored.
- instruction  output  32  fetched instruction (instrF).
- missStall  output  1  high while the current pc misses or a refill is in progress.
- memReq  output  1  refill request to backing memory.
- memAdr  output  32  word-aligned address of the current refill beat.
- memData  input  32  refill data.
- memReady  input  1  the beat on memData is valid this cycle.
- hitCount  output  32  number of cycles that were lookup hits.
- missCount  output  32  number of misses that started a refill.

Behaviour:
- Address split:
  - offset = pc[2+log2(WORDS)-1:2]
  - index = next log2(LINES) bits
  - tag = the remaining upper bits.
- Storage:
  - data array LINES x WORDS x 32
  - tag array LINES x tag width
  - valid bit per line.
- Lookup is combinational: hit = valid[index] and tag[index] == tag(pc).
- instruction = data[index][offset] when hit and state is IDLE; NOP otherwise.
- missStall = not hit, or state is not IDLE.
- State machine has two states, IDLE and REFILL.
- IDLE:
  - On a miss, latch refillBase = {pc[31:2+log2(WORDS)], zeros}.
  - Clear beat counter to 0.
  - Clear valid[index] for the latched index.
  - Increment missCount.
  - Go to REFILL next cycle.
  - On a hit, increment hitCount and stay in IDLE.
- REFILL:
  - memReq = 1 and memAdr = refillBase + 4*beat.
  - On each cycle with memReady = 1, write memData into data[latched index][beat] and increment beat.
  - When memReady = 1 on beat WORDS-1, also write the tag and set valid, then return to IDLE.
  - The first hit is possible the cycle after return.
  - memReady = 0 holds beat and address unchanged; there is no timeout.
- memReq = 0 and memAdr = 0 in IDLE.
- memReady while in IDLE is ignored.
- The refill address is latched at miss time. If pc changes during REFILL (branch redirect), the refill still completes for the latched line. The lookup then uses the new pc and may miss again.
- A pc that maps to the same index with a different tag evicts the old line. The line is invalid from refill start, so there are no stale hits.
- Counters wrap modulo 2^32. hitCount counts only IDLE-state hit cycles, including repeated cycles on the same pc.
- Reset (asynchronous, any state, including mid-refill):
  - state = IDLE, all valid = 0, beat = 0, refillBase = 0, hitCount = 0, missCount = 0.
  - Outputs after reset: memReq = 0, memAdr = 0, instruction = NOP, missStall = 1 (every line is invalid).
  - The data and tag arrays need not be reset.
- Latency:
  - hit: 0 cycles.
  - miss: 1 cycle to enter REFILL, plus WORDS ready beats, plus 1 cycle for the IDLE lookup.
  - Minimum miss penalty = WORDS + 1 stall cycles.

Test Plan:
- Cold miss: reset, pc = 0x00000000, backing memory returns 0xA0+i on beat i with memReady always 1.
  - Required: memAdr sequence 0x0, 0x4, 0x8, 0xC.
  - Required: missStall high for 5 cycles, then instruction = 0xA0.
  - Required: missCount = 1.
- Hits: after the cold miss, pc = 0x4, 0x8, 0xC.
  - Required: instruction = 0xA1, 0xA2, 0xA3 with the same-cycle result, missStall = 0.
  - Required: hitCount increments by 1 per cycle.
- Backpressure: refill with memReady toggling 1,0,0,1,1,0,1.
  - Required: memAdr is held during 0 cycles.
  - Required: exactly 4 writes land, valid is set only after beat 3.
- Conflict eviction (LINES = 16, WORDS = 4): fill pc 0x0, then pc 0x100 (same index 0, new tag).
  - Required: pc 0x100 misses and refills.
  - Required: a subsequent pc 0x0 misses again, missCount = 3.
- Redirect during refill: miss on 0x40, change pc to 0x80 after beat 1.
  - Required: the refill completes for 0x40–0x4C.
  - Required: a new miss then starts at 0x80.
  - Required: a later access to 0x40 hits.
- Reset mid-refill: assert rst after beat 2 of a refill.
  - Required: memReq drops immediately, and both counters = 0.
  - Required: the same pc misses again with a full 4-beat refill.
